fetch_seq_controller: RTL and testbench

- Parametrised instruction sequencer for the OSECPU core: fetches variable-length instructions of 1..MAX_WORDS 32-bit words from instruction memory with a configurable read latency.
- Presents the full instruction to the execute stage and holds it through a start/done handshake, which permits multi-cycle execution.
- Applies branch PC updates, and implements the CND skip and HLT halt bits in cr.
- Sits between instruction memory and the decode/execute/register-file datapath.

---
 rtl/fetch_seq_controller.sv | 167 ++++++++++++++++
 tb/tb_fetch_seq_controller.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fetch_seq_controller.sv
// rtl/fetch_seq_controller.sv - variable-length instruction fetch/execute sequencer
// Optional single-step support is enabled by defining FETCH_SEQ_STEP_EN.

`ifndef OP_LBSET
`define OP_LBSET 8'h01
`endif
`ifndef OP_LIMM32
`define OP_LIMM32 8'h02
`endif
`ifndef OP_CND
`define OP_CND 8'h04
`endif
`ifndef OP_HLT
`define OP_HLT 8'hFF
`endif
`ifndef BIT_CR_HLT
`define BIT_CR_HLT 0
`endif
`ifndef BIT_CR_SKIP
`define BIT_CR_SKIP 1
`endif

module fetch_seq_controller #(
  parameter int PC_W      = 16,
  parameter int MAX_WORDS = 2,
  parameter int LONG_LEN  = 2,
  parameter int MEM_LAT   = 1,
  parameter int RESET_PC  = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            memdata,
  output logic [PC_W-1:0]        memaddr,
  output logic                   mem_rd,
  output logic [32*MAX_WORDS-1:0] instr,
  output logic [2:0]             instr_len,
  output logic                   exec_start,
  input  logic                   exec_done,
  input  logic                   cond_lsb,
  input  logic                   pc_update_req,
  input  logic [PC_W-1:0]        pc_update_addr,
  output logic [2:0]             current_state,
  output logic [7:0]             cr,
  output logic [PC_W-1:0]        pc
`ifdef FETCH_SEQ_STEP_EN
  ,
  input  logic                   step_mode,
  input  logic                   step
`endif
);

  typedef enum logic [2:0] {
    S_FETCH_REQ  = 3'd0,
    S_FETCH_WAIT = 3'd1,
    S_EXEC       = 3'd2,
    S_HALT       = 3'd3
`ifdef FETCH_SEQ_STEP_EN
    , S_PAUSE    = 3'd4
`endif
  } state_t;

  state_t     state, next_state, fetch_first;
  logic [1:0] widx;
  logic [2:0] lat;
  logic       cr_hlt, cr_skip;
  logic [7:0] op, mem_op;
  logic [2:0] new_len, len_eff;
  logic       capture, more;

  always_comb begin
    op      = instr[31:24];
    mem_op  = memdata[31:24];
    new_len = (mem_op == `OP_LIMM32 || mem_op == `OP_LBSET) ? 3'(LONG_LEN) : 3'd1;
    // length is only known once word 0 arrives, so use the fresh decode then
    len_eff = (widx == 2'd0) ? new_len : instr_len;
    capture = (state == S_FETCH_WAIT) && (lat == 3'd1);
    more    = ({1'b0, widx} + 3'd1) < len_eff;
`ifdef FETCH_SEQ_STEP_EN
    fetch_first = step_mode ? S_PAUSE : S_FETCH_REQ;
`else
    fetch_first = S_FETCH_REQ;
`endif
    next_state = state;
    case (state)
      S_FETCH_REQ:  next_state = S_FETCH_WAIT;
      S_FETCH_WAIT: begin
        if (capture) begin
          if (more)         next_state = S_FETCH_REQ;
          else if (cr_skip) next_state = fetch_first;
          else              next_state = S_EXEC;
        end
      end
      S_EXEC: begin
        if (exec_done) next_state = (op == `OP_HLT) ? S_HALT : fetch_first;
      end
      S_HALT: next_state = S_HALT;
`ifdef FETCH_SEQ_STEP_EN
      S_PAUSE: begin
        if (step || !step_mode) next_state = S_FETCH_REQ;
      end
`endif
      default: next_state = S_FETCH_REQ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_FETCH_REQ;
      pc         <= PC_W'(RESET_PC);
      widx       <= 2'd0;
      lat        <= 3'd0;
      instr      <= '0;
      instr_len  <= 3'd0;
      cr_hlt     <= 1'b0;
      cr_skip    <= 1'b0;
      exec_start <= 1'b0;
    end else begin
      state      <= next_state;
      exec_start <= (next_state == S_EXEC) && (state != S_EXEC);
      case (state)
        S_FETCH_REQ: begin
          pc  <= pc + 1'b1;
          lat <= 3'(MEM_LAT);
        end
        S_FETCH_WAIT: begin
          lat <= lat - 3'd1;
          if (capture) begin
            for (int k = 0; k < MAX_WORDS; k++) begin
              if (k == int'(widx))      instr[32*k +: 32] <= memdata;
              else if (widx == 2'd0)    instr[32*k +: 32] <= 32'd0;
            end
            if (widx == 2'd0) instr_len <= new_len;
            if (more) begin
              widx <= widx + 2'd1;
            end else begin
              widx <= 2'd0;
              if (cr_skip) cr_skip <= 1'b0;
            end
          end
        end
        S_EXEC: begin
          if (exec_done) begin
            widx <= 2'd0;
            if (op == `OP_HLT) begin
              cr_hlt <= 1'b1;
            end else begin
              if (pc_update_req) pc <= pc_update_addr;
              cr_skip <= (op == `OP_CND) && !cond_lsb;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cr = 8'd0;
    cr[`BIT_CR_HLT]  = cr_hlt;
    cr[`BIT_CR_SKIP] = cr_skip;
  end

  assign mem_rd        = (state == S_FETCH_REQ) && !reset;
  assign memaddr       = (state == S_FETCH_REQ) ? pc : '0;
  assign current_state = state;

endmodule

// File: tb/tb_fetch_seq_controller.sv
// tb/tb_fetch_seq_controller.sv - scoreboard bench for fetch_seq_controller
module tb_fetch_seq_controller;
  localparam int PC_W = 16, MAX_WORDS = 2, LONG_LEN = 2, MEM_LAT = 2, RESET_PC = 0;
  localparam logic [7:0] OP_LBSET = 8'h01, OP_LIMM32 = 8'h02, OP_CND = 8'h04, OP_HLT = 8'hFF;

  logic clk, reset, mem_rd, exec_start, exec_done, cond_lsb, pc_update_req;
  logic [31:0] memdata;
  logic [PC_W-1:0] memaddr, pc_update_addr, pc;
  logic [32*MAX_WORDS-1:0] instr;
  logic [2:0] instr_len, current_state;
  logic [7:0] cr;

  fetch_seq_controller #(.PC_W(PC_W), .MAX_WORDS(MAX_WORDS), .LONG_LEN(LONG_LEN),
                         .MEM_LAT(MEM_LAT), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset), .memdata(memdata), .memaddr(memaddr), .mem_rd(mem_rd),
    .instr(instr), .instr_len(instr_len), .exec_start(exec_start), .exec_done(exec_done),
    .cond_lsb(cond_lsb), .pc_update_req(pc_update_req), .pc_update_addr(pc_update_addr),
    .current_state(current_state), .cr(cr), .pc(pc));

  logic [31:0] mem [0:255];
  logic [PC_W-1:0] rd_addr;
  int cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd) rd_addr <= memaddr;
    if (reset) cyc <= 0; else cyc <= cyc + 1;
  end
  assign memdata = mem[rd_addr[7:0]];

  typedef struct {
    logic [31:0] w0, w1;
    int len, pcv, delay, tgt, exp_cyc;
    bit cond, br;
  } exp_t;
  exp_t sb[$];
  int n_cmp, n_bad;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] w0, input logic [31:0] w1, input int len, input int pcv,
                      input int delay, input bit cond, input bit br, input int tgt, input int ec);
    exp_t e;
    e.w0 = w0; e.w1 = w1; e.len = len; e.pcv = pcv; e.delay = delay;
    e.cond = cond; e.br = br; e.tgt = tgt; e.exp_cyc = ec;
    sb.push_back(e);
  endtask

  // exec_done/branch noise outside EXEC must be ignored by the DUT
  task automatic wait_start(output bit ok);
    ok = 1'b0;
    exec_done = 1'b1; pc_update_req = 1'b1; pc_update_addr = 16'hFFFF; cond_lsb = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (exec_start) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic run_one(output bit ok);
    exp_t e;
    bit is_hlt, is_skip;
    wait_start(ok);
    check("exec_start_seen", {63'd0, ok}, 64'd1);
    if (!ok) return;
    e = sb.pop_front();
    check("w0", instr[31:0], e.w0);
    check("w1", instr[63:32], e.w1);
    check("len", instr_len, e.len);
    check("exec_pc", pc, e.pcv);
    check("cr_exec", cr, 0);
    if (e.exp_cyc >= 0) check("start_cyc", cyc, e.exp_cyc);
    for (int d = 0; d <= e.delay; d++) begin
      check("in_exec", current_state, 2);
      if (d > 0) check("start_pulse", exec_start, 0);
      exec_done = (d == e.delay); cond_lsb = e.cond;
      pc_update_req = e.br; pc_update_addr = e.tgt[PC_W-1:0];
      @(negedge clk);
    end
    exec_done = 1'b0; pc_update_req = 1'b0;
    is_hlt  = (e.w0[31:24] == OP_HLT);
    is_skip = (e.w0[31:24] == OP_CND) && !e.cond;
    if (is_hlt) begin
      check("halt_state", current_state, 3);
      check("halt_cr", cr, 8'h01);
    end else begin
      check("next_state", current_state, 0);
      check("next_rd", mem_rd, 1);
      check("next_addr", memaddr, e.br ? e.tgt : e.pcv);
      check("cr_after", cr, is_skip ? 8'h02 : 8'h00);
    end
  endtask

  initial begin
    bit ok;
    n_cmp = 0; n_bad = 0;
    reset = 1'b1; exec_done = 1'b0; cond_lsb = 1'b0; pc_update_req = 1'b0; pc_update_addr = '0;
    rd_addr = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    mem[8'h00] = 32'h100000AA;  mem[8'h01] = {OP_LIMM32, 24'h000011};
    mem[8'h02] = 32'hDEADBEEF;  mem[8'h03] = {OP_CND, 24'h000001};
    mem[8'h04] = {OP_LBSET, 24'h000005}; mem[8'h05] = {OP_LIMM32, 24'h0};
    mem[8'h06] = {OP_CND, 24'h000002};   mem[8'h07] = 32'h20000007;
    mem[8'h40] = {OP_LBSET, 24'h000040}; mem[8'h41] = 32'hCAFEF00D;
    mem[8'h42] = {OP_CND, 24'h000003};   mem[8'h43] = {OP_HLT, 24'h0};
    mem[8'h44] = 32'h30000044;           mem[8'h45] = {OP_HLT, 24'h000045};
    #1;
    check("rst_state", current_state, 0);
    check("rst_pc", pc, RESET_PC);
    check("rst_cr", cr, 0);
    check("rst_instr", instr, 0);
    check("rst_len", instr_len, 0);
    check("rst_start", exec_start, 0);
    check("rst_rd", mem_rd, 0);

    push(mem[8'h00], 32'd0, 1, 1, 0, 0, 0, 0, 3);
    push(mem[8'h01], mem[8'h02], 2, 3, 0, 0, 0, 0, 10);
    push(mem[8'h03], 32'd0, 1, 4, 0, 0, 0, 0, 14);
    push(mem[8'h06], 32'd0, 1, 7, 0, 1, 0, 0, 24);
    push(mem[8'h07], 32'd0, 1, 8, 3, 0, 1, 16'h0040, 28);
    push(mem[8'h40], mem[8'h41], 2, 16'h42, 1, 0, 0, 0, -1);
    push(mem[8'h42], 32'd0, 1, 16'h43, 0, 0, 0, 0, -1);
    push(mem[8'h44], 32'd0, 1, 16'h45, 2, 0, 0, 0, -1);
    push(mem[8'h45], 32'd0, 1, 16'h46, 0, 0, 1, 16'h0010, -1);

    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    while (sb.size() > 0) begin
      run_one(ok);
      if (!ok) break;
    end
    check("sb_empty", sb.size(), 0);

    exec_done = 1'b1; pc_update_req = 1'b1; pc_update_addr = 16'h0010;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("halt_rd", mem_rd, 0);
      check("halt_hold", current_state, 3);
    end
    check("halt_pc", pc, 16'h46);
    exec_done = 1'b0; pc_update_req = 1'b0;

    reset = 1'b1; #1;
    check("rst2_instr", instr, 0);
    check("rst2_cr", cr, 0);
    check("rst2_state", current_state, 0);
    check("rst2_pc", pc, RESET_PC);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("mid_wait_state", current_state, 1);
    reset = 1'b1; #1;
    check("rst3_pc", pc, RESET_PC);
    check("rst3_state", current_state, 0);
    check("rst3_cr", cr, 0);
    @(negedge clk); @(negedge clk);
    check("rst3_no_capture", instr, 0);
    check("rst3_len", instr_len, 0);
    push(mem[8'h00], 32'd0, 1, 1, 0, 0, 0, 0, 3);
    reset = 1'b0;
    run_one(ok);
    check("sb_empty2", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
